spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_master.sv | 143 ++++++++++++++
 tb/tb_spi_master.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// Command/address SPI master: sends a 2-bit command plus one byte MSB first and,
// for read-data frames, waits RD_WAIT cycles and then captures one byte from MISO.
module spi_master #(
   parameter int RD_WAIT = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [1:0] cmd,
   input  logic [7:0] din,
   input  logic       MISO,
   output logic       SS_n,
   output logic       MOSI,
   output logic       busy,
   output logic       done,
   output logic [7:0] rd_data,
   output logic       rd_valid
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_SHIFT,
      S_WAIT,
      S_RECV,
      S_END
   } state_t;

   // Last value of the wait counter before moving on to RECV.
   localparam logic [3:0] LP_WAIT_LAST = (RD_WAIT == 0) ? 4'd0 : 4'(RD_WAIT - 1);

   state_t     r_state;
   logic [9:0] r_frame;
   logic [3:0] r_bit_cnt;
   logic [3:0] r_wait_cnt;
   logic [7:0] r_rx;
   logic       r_ss_n;
   logic       r_mosi;
   logic       r_busy;
   logic       r_done;
   logic       r_rd_valid;
   logic [7:0] r_rd_data;

   logic       w_is_read;
   logic [3:0] w_next_idx;
   logic [7:0] w_rx_next;

   assign w_is_read  = (r_frame[9:8] == 2'b11);
   assign w_next_idx = 4'd8 - r_bit_cnt;
   assign w_rx_next  = {r_rx[6:0], MISO};

   // NOTE: every register here uses <= so all state updates see pre-edge values;
   // reset is synchronous, so rst_n is just the first branch of the clocked block.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_frame    <= '0;
         r_bit_cnt  <= '0;
         r_wait_cnt <= '0;
         r_rx       <= '0;
         r_ss_n     <= 1'b1;
         r_mosi     <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_rd_valid <= 1'b0;
         r_rd_data  <= '0;
      end else begin
         r_done     <= 1'b0;
         r_rd_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_frame    <= {cmd, din};
                  r_bit_cnt  <= '0;
                  r_wait_cnt <= '0;
                  r_ss_n     <= 1'b0;
                  r_mosi     <= cmd[1];
                  r_busy     <= 1'b1;
                  r_state    <= S_START;
               end
            end
            S_START: begin
               r_mosi  <= r_frame[9];
               r_state <= S_SHIFT;
            end
            S_SHIFT: begin
               if (r_bit_cnt == 4'd9) begin
                  r_mosi <= 1'b0;
                  if (!w_is_read) begin
                     r_ss_n  <= 1'b1;
                     r_done  <= 1'b1;
                     r_state <= S_END;
                  end else if (RD_WAIT == 0) begin
                     r_bit_cnt <= '0;
                     r_state   <= S_RECV;
                  end else begin
                     r_state <= S_WAIT;
                  end
               end else begin
                  // MOSI already shows bit 9-cnt; queue up the following bit.
                  r_mosi    <= r_frame[w_next_idx];
                  r_bit_cnt <= r_bit_cnt + 4'd1;
               end
            end
            S_WAIT: begin
               if (r_wait_cnt == LP_WAIT_LAST) begin
                  r_bit_cnt <= '0;
                  r_state   <= S_RECV;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 4'd1;
               end
            end
            S_RECV: begin
               r_rx <= w_rx_next;
               if (r_bit_cnt == 4'd7) begin
                  r_ss_n     <= 1'b1;
                  r_done     <= 1'b1;
                  r_rd_valid <= 1'b1;
                  r_rd_data  <= w_rx_next;
                  r_state    <= S_END;
               end else begin
                  r_bit_cnt <= r_bit_cnt + 4'd1;
               end
            end
            S_END: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign SS_n     = r_ss_n;
   assign MOSI     = r_mosi;
   assign busy     = r_busy;
   assign done     = r_done;
   assign rd_data  = r_rd_data;
   assign rd_valid = r_rd_valid;

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: stimulus pushes expected frame results, a
// negedge monitor acts as the SPI slave, collects MOSI and checks each done pulse.
module tb_spi_master;

   localparam int RW         = 2;
   localparam int RECV_FIRST = 12 + RW;
   localparam int RECV_LAST  = 19 + RW;

   typedef struct {
      int         done_cyc;
      logic       rv;
      logic [7:0] rd;
      logic [10:0] bits;
      logic       is_read;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [1:0] cmd;
   logic [7:0] din;
   logic       miso;
   logic       ss_n;
   logic       mosi;
   logic       busy;
   logic       done;
   logic [7:0] rd_data;
   logic       rd_valid;

   logic       start0;
   logic [1:0] cmd0;
   logic [7:0] din0;
   logic       miso0;
   logic       ss_n0;
   logic       mosi0;
   logic       busy0;
   logic       done0;
   logic [7:0] rd_data0;
   logic       rd_valid0;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   exp_t        q[$];
   logic [7:0]  held_rd  = 8'h00;
   logic [7:0]  slave_byte = 8'h00;

   int          low_cnt = 0;
   int          hi_cnt  = 0;
   int          last_hi = 0;
   logic [10:0] mosi_bits = '0;
   logic        stray_mosi = 1'b0;

   spi_master #(.RD_WAIT(RW)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cmd(cmd), .din(din), .MISO(miso),
      .SS_n(ss_n), .MOSI(mosi), .busy(busy), .done(done), .rd_data(rd_data),
      .rd_valid(rd_valid)
   );

   spi_master #(.RD_WAIT(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .cmd(cmd0), .din(din0), .MISO(miso0),
      .SS_n(ss_n0), .MOSI(mosi0), .busy(busy0), .done(done0), .rd_data(rd_data0),
      .rd_valid(rd_valid0)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Slave model, MOSI collector and scoreboard checker.
   always @(negedge clk) begin
      exp_t e;
      if (ss_n === 1'b0) begin
         low_cnt++;
         if (low_cnt <= 11) mosi_bits = {mosi_bits[9:0], mosi};
         else if (mosi !== 1'b0) stray_mosi = 1'b1;
         if (hi_cnt != 0) begin
            last_hi = hi_cnt;
            hi_cnt  = 0;
         end
      end else begin
         hi_cnt++;
      end
      if (done === 1'b1) begin
         if (q.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            e = q.pop_front();
            check("done_cycle", cyc, e.done_cyc);
            check("rd_valid", rd_valid, e.rv);
            check("rd_data", rd_data, e.rd);
            check("mosi_bits", mosi_bits, e.bits);
            check("mosi_zero_after_shift", stray_mosi, 0);
            check("ss_n_at_done", ss_n, 1);
            if (!e.is_read) check("ss_low_cycles", low_cnt, 11);
         end
      end else if (rd_valid === 1'b1) begin
         check("stray_rd_valid", 1, 0);
      end
      if (ss_n !== 1'b0) begin
         low_cnt    = 0;
         mosi_bits  = '0;
         stray_mosi = 1'b0;
      end
      miso = (low_cnt >= RECV_FIRST && low_cnt <= RECV_LAST) ?
             slave_byte[RECV_LAST - low_cnt] : 1'b0;
   end

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (q.size() == 0 && busy === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
      check("frame_complete_in_time", ok, 1);
   endtask

   task automatic push_exp(input int done_cyc, input logic [1:0] c, input logic [7:0] d);
      exp_t e;
      e.done_cyc = done_cyc;
      e.is_read  = (c == 2'b11);
      e.rv       = e.is_read;
      e.rd       = held_rd;
      e.bits     = {c[1], c, d};
      q.push_back(e);
   endtask

   // One frame; cmd/din are scrambled right after accept to show they are latched.
   task automatic send(input logic [1:0] c, input logic [7:0] d, input logic [7:0] sb);
      @(negedge clk);
      start = 1'b1;
      cmd   = c;
      din   = d;
      slave_byte = sb;
      if (c == 2'b11) held_rd = sb;
      push_exp(cyc + ((c == 2'b11) ? 20 + RW : 12), c, d);
      @(negedge clk);
      start = 1'b0;
      cmd   = ~c;
      din   = ~d;
      wait_idle();
   endtask

   initial begin
      int  c0;
      int  dc;
      bit  got;

      rst_n = 1'b0; start = 1'b1; cmd = 2'b11; din = 8'hFF;
      start0 = 1'b1; cmd0 = 2'b11; din0 = 8'hFF; miso0 = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ss_n", ss_n, 1);
      check("rst_mosi", mosi, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_rd_valid", rd_valid, 0);
      check("rst_rd_data", rd_data, 8'h00);
      check("rst_busy0", busy0, 0);
      rst_n = 1'b1; start = 1'b0; start0 = 1'b0;
      @(negedge clk);
      check("idle_after_release", busy, 0);

      send(2'b00, 8'hA5, 8'h00);
      send(2'b11, 8'h00, 8'h3C);
      send(2'b01, 8'h5A, 8'h00);
      send(2'b10, 8'h81, 8'h00);
      send(2'b11, 8'h7E, 8'hC3);

      // Back-to-back write-data frames with start held high.
      @(negedge clk);
      start = 1'b1; cmd = 2'b01; din = 8'h12;
      c0 = cyc;
      push_exp(c0 + 12, 2'b01, 8'h12);
      push_exp(c0 + 25, 2'b01, 8'h34);
      @(negedge clk);
      din = 8'h34;
      repeat (14) @(negedge clk);
      start = 1'b0;
      wait_idle();
      check("ss_high_between_frames", last_hi, 2);

      // Reset at SHIFT bit 5 of a read-data frame, with start held during reset.
      @(negedge clk);
      start = 1'b1; cmd = 2'b11; din = 8'h66; slave_byte = 8'hAA;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      rst_n = 1'b0; start = 1'b1;
      @(negedge clk);
      held_rd = 8'h00;
      check("abort_ss_n", ss_n, 1);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_rd_valid", rd_valid, 0);
      check("abort_rd_data", rd_data, 8'h00);
      @(negedge clk);
      check("start_in_reset_ignored", busy, 0);
      rst_n = 1'b1; start = 1'b0;
      send(2'b01, 8'hC7, 8'h00);

      // Input changes and a start pulse during SHIFT must not disturb the frame.
      @(negedge clk);
      start = 1'b1; cmd = 2'b00; din = 8'h5A;
      push_exp(cyc + 12, 2'b00, 8'h5A);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      cmd = 2'b11; din = 8'hFF; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle();
      repeat (5) @(negedge clk);
      check("no_extra_frame", busy, 0);

      // RD_WAIT=0 instance: read-data frame completes at cycle 20.
      @(negedge clk);
      start0 = 1'b1; cmd0 = 2'b11; din0 = 8'h00; miso0 = 1'b1;
      c0 = cyc;
      @(negedge clk);
      start0 = 1'b0;
      got = 1'b0;
      dc  = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (done0 === 1'b1) begin
            got = 1'b1;
            dc  = cyc;
            break;
         end
      end
      check("rw0_done_seen", got, 1);
      check("rw0_done_cycle", dc, c0 + 20);
      check("rw0_rd_valid", rd_valid0, 1);
      check("rw0_rd_data", rd_data0, 8'hFF);

      repeat (3) @(negedge clk);
      check("scoreboard_drained", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule
